// File: rtl/regfile_mp_pkg.sv
// Shared constants, types and the write-port match helper for regfile_mp.
// MAX_WR / MAX_ADDR_W bound the padded vectors that wr_match() operates on.
package regfile_mp_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int NUM_WR_DEF   = 1;

    localparam int MAX_WR     = 8;
    localparam int MAX_ADDR_W = 16;
    localparam int WR_IDX_W   = $clog2(MAX_WR);

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] idx;
    } wr_match_t;

    // Scanning upward lets the highest-numbered matching port overwrite earlier hits.
    function automatic wr_match_t wr_match(
        input logic [MAX_ADDR_W-1:0]             addr,
        input logic [MAX_WR-1:0]                 wr_en,
        input logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wr_addr
    );
        wr_match_t m;
        m = '0;
        for (int i = 0; i < MAX_WR; i++) begin
            if (wr_en[i] && wr_addr[i] == addr) begin
                m.hit = 1'b1;
                m.idx = WR_IDX_W'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// One registered read port: address masking, optional write bypass, output flops.
// Bypass is compiled in with REGFILE_MP_BYPASS_EN.
module regfile_mp_rdport
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [DATA_W-1:0]             regs [NUM_REGS],
    input  logic [NUM_REGS-1:0]           busy_vec,
`ifdef REGFILE_MP_BYPASS_EN
    input  logic [MAX_WR-1:0]             wr_en_pad,
    input  logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wr_addr_pad,
    input  logic [MAX_WR-1:0][DATA_W-1:0] wr_data_pad,
`endif
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_busy
);

    logic              addr_ok;
    logic [DATA_W-1:0] data_nxt;
    logic              busy_nxt;
`ifdef REGFILE_MP_BYPASS_EN
    wr_match_t         byp;
`endif

    // NOTE: every combinational output is given a default first so no path can infer a latch.
    always_comb begin
        addr_ok  = (int'(rd_addr) < NUM_REGS) && !(ZERO_REG && rd_addr == '0);
        data_nxt = '0;
        busy_nxt = 1'b0;
        if (addr_ok) begin
            data_nxt = regs[rd_addr];
            busy_nxt = busy_vec[rd_addr];
        end
`ifdef REGFILE_MP_BYPASS_EN
        byp = wr_match(MAX_ADDR_W'(rd_addr), wr_en_pad, wr_addr_pad);
        if (addr_ok && byp.hit) begin
            data_nxt = wr_data_pad[byp.idx];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_data <= data_nxt;
            rd_busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard.
// Optional write-to-read bypass selected by REGFILE_MP_BYPASS_EN.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr
);

    logic [DATA_W-1:0]                 regs [NUM_REGS];
    logic [NUM_REGS-1:0]               busy;
    logic [NUM_REGS-1:0]               busy_nxt;
    logic [NUM_REGS-1:0]               reg_wr;
    wr_match_t                         reg_hit [NUM_REGS];
    logic [MAX_WR-1:0]                 wr_en_pad;
    logic [MAX_WR-1:0][MAX_ADDR_W-1:0] wr_addr_pad;

    always_comb begin
        wr_en_pad   = '0;
        wr_addr_pad = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wr_en_pad[i]   = wr_en[i];
            wr_addr_pad[i] = MAX_ADDR_W'(wr_addr[i*ADDR_W +: ADDR_W]);
        end
    end

    // Write clears busy, a same-cycle set overrides the clear, r0 never goes busy.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            reg_hit[r]  = wr_match(MAX_ADDR_W'(r), wr_en_pad, wr_addr_pad);
            reg_wr[r]   = reg_hit[r].hit && !(ZERO_REG && r == 0);
            busy_nxt[r] = busy[r];
            if (reg_wr[r])
                busy_nxt[r] = 1'b0;
            if (busy_set && int'(busy_addr) == r)
                busy_nxt[r] = 1'b1;
            if (ZERO_REG && r == 0)
                busy_nxt[r] = 1'b0;
        end
    end

    // NOTE: the storage is built from flops with a defined reset value, so it is cleared here
    // unlike an SRAM macro; sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else begin
            busy <= busy_nxt;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (reg_wr[r])
                    regs[r] <= wr_data[reg_hit[r].idx*DATA_W +: DATA_W];
            end
        end
    end

`ifdef REGFILE_MP_BYPASS_EN
    logic [MAX_WR-1:0][DATA_W-1:0] wr_data_pad;

    always_comb begin
        wr_data_pad = '0;
        for (int i = 0; i < NUM_WR; i++)
            wr_data_pad[i] = wr_data[i*DATA_W +: DATA_W];
    end
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_mp_rdport #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .clk         (clk),
            .rst_n       (rst_n),
            .rd_en       (rd_en[p]),
            .rd_addr     (rd_addr[p*ADDR_W +: ADDR_W]),
            .regs        (regs),
`ifdef REGFILE_MP_BYPASS_EN
            .busy_vec    (busy_nxt),
            .wr_en_pad   (wr_en_pad),
            .wr_addr_pad (wr_addr_pad),
            .wr_data_pad (wr_data_pad),
`else
            .busy_vec    (busy),
`endif
            .rd_data     (rd_data[p*DATA_W +: DATA_W]),
            .rd_busy     (rd_busy[p])
        );
    end

endmodule
